// File: rtl/cpu_fetch_pkg.sv
// Shared constants and entry layout for the instruction fetch unit.
package cpu_fetch_pkg;

  localparam int              ADDR_W       = 16;
  localparam int              DATA_W       = 32;
  localparam logic [15:0]     RESET_VECTOR = 16'h8000;
  localparam logic [15:0]     ROM_BASE     = 16'h8000;
  localparam logic [15:0]     ROM_LAST     = 16'h8FFF;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for prefetched {pc, instr} entries; flush beats push.
module fetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;

  // Storage is cleared on reset so the head reads zero before any fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, ROM strobe, prefetch queue and branch redirect.
// Optional ROM window fault detection is enabled by ROM_WINDOW_CHECK_EN.
module instr_fetch
  import cpu_fetch_pkg::*;
#(
  parameter int                ADDR_W   = cpu_fetch_pkg::ADDR_W,
  parameter int                DATA_W   = cpu_fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR,
`ifdef ROM_WINDOW_CHECK_EN
  parameter logic [ADDR_W-1:0] ROM_BASE = cpu_fetch_pkg::ROM_BASE,
  parameter logic [ADDR_W-1:0] ROM_LAST = cpu_fetch_pkg::ROM_LAST,
`endif
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef ROM_WINDOW_CHECK_EN
  ,
  output logic              fetch_fault
`endif
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] head;
  logic               pop;
  logic               in_window;

`ifdef ROM_WINDOW_CHECK_EN
  assign in_window = (pc >= ROM_BASE) && (pc <= ROM_LAST);
`else
  assign in_window = 1'b1;
`endif

  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  assign rom_address = pc;
  // A full queue can still take a fetch when the head leaves on the same edge.
  assign rom_oe      = !redirect_valid && in_window &&
                       ((count < CNT_W'(DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (rom_oe)         pc <= pc + 1'b1;
  end

`ifdef ROM_WINDOW_CHECK_EN
  // Sticky until a redirect lands back inside the window.
  always_ff @(posedge clk) begin
    if (rst)
      fetch_fault <= 1'b0;
    else if (redirect_valid) begin
      if ((redirect_pc >= ROM_BASE) && (redirect_pc <= ROM_LAST))
        fetch_fault <= 1'b0;
    end else if (!in_window)
      fetch_fault <= 1'b1;
  end
`endif

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rom_oe),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc, rom_out}),
    .head  (head),
    .count (count)
  );

  assign out_pc    = head[ENTRY_W-1 -: ADDR_W];
  assign out_instr = head[DATA_W-1:0];

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch initiator for the program ROM. Owns the program counter, drives the ROM address and output-enable, and captures the 32-bit word returned combinationally. Buffers fetched words with their PCs in a small prefetch queue. Hands entries to the decode stage over a valid/ready handshake, and accepts branch redirects that flush the queue.

Parameters:
ADDR_W, 16, ROM address / PC width (word addressed)
DATA_W, 32, instruction width
RESET_PC, 16'h8000, PC loaded on reset
DEPTH, 2, prefetch queue entries (power of two, >=2)
ROM_BASE, 16'h8000, first valid ROM word (used only with the optional feature)
ROM_LAST, 16'h8FFF, last valid ROM word (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  reset
rom_address  output  ADDR_W  ROM word address, always equals the current PC
rom_oe  output  1  ROM output enable (fetch strobe)
rom_out  input  DATA_W  ROM data, valid in the same cycle as rom_address/rom_oe
out_valid  output  1  decode-side entry available
out_ready  input  1  decode stage accepts the head entry
out_instr  output  DATA_W  head instruction word
out_pc  output  ADDR_W  PC of the head instruction
redirect_valid  input  1  branch/jump taken
redirect_pc  input  ADDR_W  new fetch target

Behaviour:
- One clock, clk. rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset state: pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0. rom_oe may be 1 in the first cycle after reset release.
- rom_address = pc (registered).
- rom_oe is combinational:
  - rom_oe = !redirect_valid && (count<DEPTH || (out_valid && out_ready)).
- Fetch: at an edge where rom_oe=1, the block pushes {pc, rom_out} into the queue and sets pc <= pc+1.
- PC increment wraps modulo 2^ADDR_W: 16'hFFFF -> 16'h0000.
- Pop: at an edge where out_valid && out_ready, the head is removed. Push and pop in the same cycle are legal, including when the queue is full; count is then unchanged.
- out_valid = (count!=0). out_instr and out_pc come directly from the queue head. Ordering is FIFO; entries are never reordered or duplicated.
- Latency:
  - First instruction is presented with out_valid=1 in the 2nd cycle after rst deasserts: cycle 0 fetches 0x8000, cycle 1 presents it.
  - Steady-state throughput is 1 instruction/cycle while out_ready=1.
- Redirect at an edge with redirect_valid=1:
  - Queue is flushed (count <= 0) and pc <= redirect_pc.
  - No fetch occurs that cycle (rom_oe=0).
  - A pop in the same cycle is still considered consumed by decode.
  - Next cycle fetches redirect_pc. out_valid is 0 for exactly one cycle, then that entry appears.
- Back-to-back redirects: the last one wins. Redirect has priority over fetch and over reset-free queue updates; rst has priority over everything.
- Reset mid-operation: the queue is discarded and pc returns to RESET_PC on the same edge.
- Stall: with out_ready=0 the queue fills to DEPTH, then rom_oe=0 and pc holds. out_instr and out_pc stay stable while out_valid=1 and out_ready=0.

Optional Feature:
ROM_WINDOW_CHECK_EN
- Defined:
  - Adds output fetch_fault (1 bit, reset 0).
  - If pc<ROM_BASE or pc>ROM_LAST, rom_oe is forced to 0, pc holds, and fetch_fault is set at the next edge.
  - fetch_fault is sticky until a redirect into [ROM_BASE, ROM_LAST] or rst.
  - Entries already queued still drain normally.
- Undefined:
  - No fetch_fault port.
  - Every address is fetched; out-of-window reads return whatever the ROM returns (its default word 0).

Decomposition:
- Package cpu_fetch_pkg holds:
  - constants ADDR_W, DATA_W, RESET_VECTOR (16'h8000), ROM_BASE, ROM_LAST;
  - typedef fetch_entry_t = {pc[ADDR_W], instr[DATA_W]}.
- One sub-module, fetch_fifo: parameterised DEPTH synchronous FIFO with push, pop, flush, count, and head output; flush has priority over push.
- PC and redirect logic stay in instr_fetch.

Test Plan:
- Reset release with out_ready=1 and a ROM model returning {16'hA5A5, addr} -> rom_address 8000, 8001, 8002... on consecutive cycles; out_pc 8000 with out_instr 32'hA5A58000 in cycle 1, then one entry per cycle.
- out_ready held 0 for 5 cycles -> count saturates at 2, rom_oe=0, rom_address holds 8002; on release, 8000, 8001, 8002 emerge in order with no loss or duplication.
- redirect_valid with redirect_pc=8010 while the queue is full -> next cycle out_valid=0 and rom_address=8010; following cycle out_pc=8010.
- Redirect to FFFF with a free-running fetch -> out_pc sequence FFFF, 0000, 0001 (wrap).
- rst asserted while the queue holds 2 entries and a redirect is pending -> next cycle out_valid=0 and rom_address=8000.
- With ROM_WINDOW_CHECK_EN: redirect to 8FFE -> 8FFE and 8FFF are delivered, fetch_fault rises after pc reaches 9000, rom_oe=0; redirect to 8000 clears fetch_fault.
